// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: sequences each instruction through 3-5 states,
// waits on a variable-latency memory handshake, and traps illegal opcodes.
module mips_multicycle_ctrl #(
  parameter bit EN_BYTE      = 1'b1,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       alusrca,
  output logic       branch,
  output logic       bne,
  output logic       jal,
  output logic       lb,
  output logic       sb,
  output logic [1:0] regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal,
  output logic [3:0] state
);

  // state     | meaning
  // FETCH     | read instruction at PC, PC <= PC+4 on mem_ready
  // DECODE    | read registers, precompute branch target
  // MEMADR    | compute load/store address
  // MEMREAD   | load access, wait for mem_ready
  // MEMWB     | write load data to rt
  // MEMWRITE  | store access, wait for mem_ready
  // EXECUTE   | R-type ALU operation
  // ALUWB     | write ALU result to rd
  // BRANCH    | compare and conditionally redirect PC
  // IEXEC     | immediate ALU operation
  // IWB       | write immediate result to rt
  // JUMP      | jump, plus link write for JAL
  // ILLEGAL   | unsupported opcode seen
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_IEXEC    = 4'd9,
    S_IWB      = 4'd10,
    S_JUMP     = 4'd11,
    S_ILLEGAL  = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  state_e state_q, state_d;

  logic is_lb, is_sb, is_load, is_store, is_slti;

  assign is_lb    = EN_BYTE && (op == OP_LB);
  assign is_sb    = EN_BYTE && (op == OP_SB);
  assign is_load  = (op == OP_LW) || is_lb;
  assign is_store = (op == OP_SW) || is_sb;
  assign is_slti  = (op == OP_SLTI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (op == OP_RTYPE)                      state_d = S_EXECUTE;
        else if (is_load || is_store)            state_d = S_MEMADR;
        else if (op == OP_BEQ || op == OP_BNE)   state_d = S_BRANCH;
        else if (op == OP_ADDI || is_slti)       state_d = S_IEXEC;
        else if (op == OP_J || op == OP_JAL)     state_d = S_JUMP;
        else                                     state_d = S_ILLEGAL;
      end
      S_MEMADR:   state_d = is_store ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_IEXEC:    state_d = S_IWB;
      S_IWB:      state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_ILLEGAL:  state_d = TRAP_ILLEGAL ? S_ILLEGAL : S_FETCH;
      default:    state_d = S_ILLEGAL;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    regwrite = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    branch   = 1'b0;
    bne      = 1'b0;
    jal      = 1'b0;
    lb       = 1'b0;
    sb       = 1'b0;
    regdst   = 2'b00;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    illegal  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        // Reset must not let a fetch commit even if memory happens to be ready.
        irwrite = mem_ready & ~reset;
        pcwrite = mem_ready & ~reset;
      end
      S_DECODE:   alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        lb       = (op == OP_LB);
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        sb       = (op == OP_SB);
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 2'b01;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = (op == OP_BEQ);
        bne     = (op == OP_BNE);
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = is_slti ? 2'b11 : 2'b00;
      end
      S_IWB: begin
        regwrite = 1'b1;
        aluop    = is_slti ? 2'b11 : 2'b00;
      end
      S_JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
        // PC already holds PC+4 here, which is the link value for JAL.
        if (op == OP_JAL) begin
          regwrite = 1'b1;
          regdst   = 2'b10;
          jal      = 1'b1;
        end
      end
      S_ILLEGAL:  illegal = 1'b1;
      default:    illegal = 1'b1;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: three controller variants share stimulus and are compared each
// cycle against an instruction-plan model, plus literal latency/trace checks.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;

  logic [2:0] mem_req_w, iord_w, irwrite_w, pcwrite_w, regwrite_w, memwrite_w, memtoreg_w;
  logic [2:0] alusrca_w, branch_w, bne_w, jal_w, lb_w, sb_w, illegal_w;
  logic [1:0] regdst_w [3];
  logic [1:0] alusrcb_w [3];
  logic [1:0] pcsrc_w [3];
  logic [1:0] aluop_w [3];
  logic [3:0] state_w [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.EN_BYTE(1'b1), .TRAP_ILLEGAL(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req_w[0]), .iord(iord_w[0]), .irwrite(irwrite_w[0]), .pcwrite(pcwrite_w[0]),
    .regwrite(regwrite_w[0]), .memwrite(memwrite_w[0]), .memtoreg(memtoreg_w[0]),
    .alusrca(alusrca_w[0]), .branch(branch_w[0]), .bne(bne_w[0]), .jal(jal_w[0]),
    .lb(lb_w[0]), .sb(sb_w[0]), .regdst(regdst_w[0]), .alusrcb(alusrcb_w[0]),
    .pcsrc(pcsrc_w[0]), .aluop(aluop_w[0]), .illegal(illegal_w[0]), .state(state_w[0]));

  mips_multicycle_ctrl #(.EN_BYTE(1'b0), .TRAP_ILLEGAL(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req_w[1]), .iord(iord_w[1]), .irwrite(irwrite_w[1]), .pcwrite(pcwrite_w[1]),
    .regwrite(regwrite_w[1]), .memwrite(memwrite_w[1]), .memtoreg(memtoreg_w[1]),
    .alusrca(alusrca_w[1]), .branch(branch_w[1]), .bne(bne_w[1]), .jal(jal_w[1]),
    .lb(lb_w[1]), .sb(sb_w[1]), .regdst(regdst_w[1]), .alusrcb(alusrcb_w[1]),
    .pcsrc(pcsrc_w[1]), .aluop(aluop_w[1]), .illegal(illegal_w[1]), .state(state_w[1]));

  mips_multicycle_ctrl #(.EN_BYTE(1'b0), .TRAP_ILLEGAL(1'b0)) u_dut2 (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req_w[2]), .iord(iord_w[2]), .irwrite(irwrite_w[2]), .pcwrite(pcwrite_w[2]),
    .regwrite(regwrite_w[2]), .memwrite(memwrite_w[2]), .memtoreg(memtoreg_w[2]),
    .alusrca(alusrca_w[2]), .branch(branch_w[2]), .bne(bne_w[2]), .jal(jal_w[2]),
    .lb(lb_w[2]), .sb(sb_w[2]), .regdst(regdst_w[2]), .alusrcb(alusrcb_w[2]),
    .pcsrc(pcsrc_w[2]), .aluop(aluop_w[2]), .illegal(illegal_w[2]), .state(state_w[2]));

  // Model: at each completed fetch the whole instruction is expanded into a plan of
  // states; memory states stall on mem_ready, illegal handling depends on the variant.
  int cur [3] = '{0, 0, 0};
  int pl [3][3];
  int pn [3] = '{0, 0, 0};
  int pix [3] = '{0, 0, 0};

  task automatic set_plan(input int v, input int n, input int a, input int b, input int c);
    pl[v][0] = a; pl[v][1] = b; pl[v][2] = c; pn[v] = n; pix[v] = 0;
  endtask

  task automatic build_plan(input int v);
    bit en_byte;
    en_byte = (v == 0);
    case (op)
      6'b000000:               set_plan(v, 2, 6, 7, 0);
      6'b100011:               set_plan(v, 3, 2, 3, 4);
      6'b101011:               set_plan(v, 2, 2, 5, 0);
      6'b000100, 6'b000101:    set_plan(v, 1, 8, 0, 0);
      6'b001000, 6'b001010:    set_plan(v, 2, 9, 10, 0);
      6'b000010, 6'b000011:    set_plan(v, 1, 11, 0, 0);
      6'b100000: if (en_byte)  set_plan(v, 3, 2, 3, 4); else set_plan(v, 1, 15, 0, 0);
      6'b101000: if (en_byte)  set_plan(v, 2, 2, 5, 0); else set_plan(v, 1, 15, 0, 0);
      default:                 set_plan(v, 1, 15, 0, 0);
    endcase
  endtask

  task automatic advance(input int v);
    if (pix[v] < pn[v]) begin
      cur[v] = pl[v][pix[v]];
      pix[v] = pix[v] + 1;
    end else begin
      cur[v] = 0;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    for (int v = 0; v < 3; v++) begin
      if (reset) begin
        cur[v] = 0;
        pn[v] = 0;
      end else begin
        case (cur[v])
          0:       if (mem_ready) begin cur[v] = 1; build_plan(v); end
          3, 5:    if (mem_ready) advance(v);
          15:      if (v == 2) cur[v] = 0;
          default: advance(v);
        endcase
      end
    end
  end

  function automatic logic [25:0] exp_vec(input int s, input logic [5:0] o, input logic rdy, input logic rst);
    logic mreq, io, irw, pcw, rw, mw, m2r, asa, br, bn, jl, lbx, sbx, ill;
    logic [1:0] rd, asb, pcs, aop;
    {mreq, io, irw, pcw, rw, mw, m2r, asa, br, bn, jl, lbx, sbx, ill} = '0;
    {rd, asb, pcs, aop} = '0;
    case (s)
      0:  begin mreq = 1; asb = 2'b01; irw = rdy & ~rst; pcw = rdy & ~rst; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mreq = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; lbx = (o == 6'b100000); end
      5:  begin mreq = 1; io = 1; mw = 1; sbx = (o == 6'b101000); end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 2'b01; end
      8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; br = (o == 6'b000100); bn = (o == 6'b000101); end
      9:  begin asa = 1; asb = 2'b10; aop = (o == 6'b001010) ? 2'b11 : 2'b00; end
      10: begin rw = 1; aop = (o == 6'b001010) ? 2'b11 : 2'b00; end
      11: begin pcw = 1; pcs = 2'b10; if (o == 6'b000011) begin rw = 1; rd = 2'b10; jl = 1; end end
      default: ill = 1;
    endcase
    return {mreq, io, irw, pcw, rw, mw, m2r, asa, br, bn, jl, lbx, sbx, rd, asb, pcs, aop, ill, 4'(s)};
  endfunction

  function automatic logic [25:0] dut_vec(input int v);
    return {mem_req_w[v], iord_w[v], irwrite_w[v], pcwrite_w[v], regwrite_w[v], memwrite_w[v],
            memtoreg_w[v], alusrca_w[v], branch_w[v], bne_w[v], jal_w[v], lb_w[v], sb_w[v],
            regdst_w[v], alusrcb_w[v], pcsrc_w[v], aluop_w[v], illegal_w[v], state_w[v]};
  endfunction

  // Per-instruction observations of instance 0 (and illegal pulses of 1/2).
  logic [31:0] tr;
  int tr_n, mw_cycles, commits, rw_cycles, lb_cycles, sb_cycles;
  int ill_cnt [3];

  task automatic clear_obs();
    tr = '0; tr_n = 0; mw_cycles = 0; commits = 0; rw_cycles = 0; lb_cycles = 0; sb_cycles = 0;
    for (int v = 0; v < 3; v++) ill_cnt[v] = 0;
  endtask

  always @(negedge clk) begin
    for (int v = 0; v < 3; v++) begin
      logic [25:0] want;
      want = exp_vec(cur[v], op, mem_ready, reset);
      checks++;
      if (dut_vec(v) !== want) begin
        failures++;
        $display("FAIL model_cmp inst=%0d t=%0t op=%b got=%h want=%h", v, $time, op, dut_vec(v), want);
      end
      if (illegal_w[v]) ill_cnt[v]++;
    end
    tr = {tr[27:0], state_w[0]};
    tr_n++;
    if (memwrite_w[0]) mw_cycles++;
    if (memwrite_w[0] && mem_ready) commits++;
    if (regwrite_w[0]) rw_cycles++;
    if (lb_w[0]) lb_cycles++;
    if (sb_w[0]) sb_cycles++;
  end

  task automatic check(input string nm, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Runs one instruction on instance 0 from FETCH back to FETCH; memory answers after
  // the requested number of wait cycles and mem_ready is random in non-memory states.
  task automatic run_instr(input logic [5:0] o, input int fw, input int mw, input int exp_cyc, input string nm);
    int f, m, cyc;
    bit left;
    f = fw; m = mw; cyc = 0; left = 0;
    op = o;
    clear_obs();
    while (cyc < 40 && !(left && state_w[0] == 4'd0)) begin
      if (state_w[0] == 4'd0) begin
        mem_ready = (f == 0); if (f > 0) f--;
      end else if (state_w[0] == 4'd3 || state_w[0] == 4'd5) begin
        mem_ready = (m == 0); if (m > 0) m--;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
      if (state_w[0] != 4'd0) left = 1;
    end
    check({nm, "_cycles"}, cyc, exp_cyc);
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; op = 6'b000000; mem_ready = 1'b1;
    @(negedge clk);
    check("rst_state", state_w[0], 0);
    check("rst_irwrite_forced", irwrite_w[0], 0);
    check("rst_pcwrite_forced", pcwrite_w[0], 0);
    check("rst_mem_req", mem_req_w[0], 1);
    check("rst_alusrcb", alusrcb_w[0], 1);
    @(posedge clk); #1 reset = 1'b0;

    run_instr(6'b100011, 0, 0, 5, "lw");
    check("lw_trace", {tr_n[7:0], tr}, {8'd5, 32'h0000_1234});
    check("lw_regwrite_cycles", rw_cycles, 1);
    run_instr(6'b101011, 0, 3, 7, "sw_wait");
    check("sw_memwrite_cycles", mw_cycles, 4);
    check("sw_commits", commits, 1);
    run_instr(6'b000011, 0, 0, 3, "jal");
    check("jal_trace", {tr_n[7:0], tr}, {8'd3, 32'h0000_001B});
    run_instr(6'b001010, 0, 0, 4, "slti");
    check("slti_trace", {tr_n[7:0], tr}, {8'd4, 32'h0000_019A});
    run_instr(6'b000101, 0, 0, 3, "bne");
    check("bne_trace", {tr_n[7:0], tr}, {8'd3, 32'h0000_0018});
    run_instr(6'b000000, 2, 0, 6, "rtype_fetch_wait");
    run_instr(6'b001000, 0, 0, 4, "addi");
    run_instr(6'b000100, 0, 0, 3, "beq");
    run_instr(6'b000010, 0, 0, 3, "j");
    run_instr(6'b100011, 1, 2, 8, "lw_wait");

    // Reset while a load is stalled in MEMREAD.
    op = 6'b100011; mem_ready = 1'b1; n = 0;
    while (state_w[0] != 4'd3 && n < 10) begin @(posedge clk); #1; n++; end
    check("reach_memread", state_w[0], 3);
    mem_ready = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    #1;
    check("async_rst_state", state_w[0], 0);
    check("async_rst_regwrite", regwrite_w[0], 0);
    check("async_rst_memwrite", memwrite_w[0], 0);
    @(posedge clk); #1 reset = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    check("post_rst_mem_req", mem_req_w[0], 1);
    @(posedge clk); #1;
    do_reset();

    // LB: decoded on instance 0, illegal on the EN_BYTE=0 variants.
    run_instr(6'b100000, 0, 0, 5, "lb");
    check("lb_flag_cycles", lb_cycles, 1);
    check("pulse_illegal_cycles", ill_cnt[2], 1);
    check("trap_state", state_w[1], 15);
    op = 6'b000000; mem_ready = 1'b1;
    clear_obs();
    repeat (12) begin @(posedge clk); #1; end
    check("trap_illegal_hold", ill_cnt[1], 12);
    do_reset();

    run_instr(6'b101000, 0, 1, 5, "sb_wait");
    check("sb_flag_cycles", sb_cycles, 2);
    check("sb_commits", commits, 1);

    // Undefined opcode traps instance 0 too.
    op = 6'b111111; mem_ready = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    check("illegal_op_state", state_w[0], 15);
    check("illegal_op_flag", illegal_w[0], 1);
    do_reset();
    repeat (2) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
